packet_injector: RTL
====================

// Module: packet_injector
// PURPOSE
//  Network-interface transmitter at a router's local input port. Accepts a packet request
//  (absolute destination, length), builds the HEAD flit, streams BODY/TAIL payload flits.
//  Header carries signed relative address {y_rel,x_rel} = dest - local, as decoded hop-by-hop
//  by address_compute (x>0 east, x<0 west, y>0 north, y<0 south, 0/0 local).
// PARAMETERS
//  address_length   16  relative address field width, {y,x}, y in upper bits
//  x_address_length 8   signed x offset width; coordinates < 2**(x_address_length-1)
//  y_address_length 8   signed y offset width; coordinates < 2**(y_address_length-1)
//  DATA_WIDTH       32  flit payload width; must be >= address_length + LEN_WIDTH
//  LEN_WIDTH        4   payload-length field width (0..2**LEN_WIDTH-1 body flits)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  asynchronous reset, active-high
//  local_x      in   x_address_length   this node's x coordinate (static)
//  local_y      in   y_address_length   this node's y coordinate (static)
//  pkt_valid    in   1                  packet request valid
//  pkt_ready    out  1                  request accepted when pkt_valid & pkt_ready
//  pkt_dest_x   in   x_address_length   absolute destination x
//  pkt_dest_y   in   y_address_length   absolute destination y
//  pkt_len      in   LEN_WIDTH          number of payload flits after HEAD
//  data_valid   in   1                  payload word valid
//  data_ready   out  1                  payload word accepted when data_valid & data_ready
//  data_in      in   DATA_WIDTH         payload word
//  flit_valid   out  1                  output flit valid (registered)
//  flit_ready   in   1                  router local port accepts flit
//  flit_type    out  2                  00 BODY, 01 HEAD, 10 TAIL, 11 HEAD_TAIL (registered)
//  flit_data    out  DATA_WIDTH         flit payload (registered)
//  busy         out  1                  packet in progress or output flit pending
//  pkt_count    out  16                 packets fully sent (TAIL/HEAD_TAIL accepted), wraps
// BEHAVIOUR
//  Reset: state IDLE, flit_valid=0, flit_type=0, flit_data=0, remaining=0, pkt_count=0;
//   pkt_ready=0 and data_ready=0 while rst high. Reset mid-packet drops the packet silently.
//  Output register: one entry; "can_load" = !flit_valid | flit_ready. flit_valid/type/data
//   held stable until flit_ready while flit_valid (never change under backpressure).
//  FSM IDLE: pkt_ready = can_load. On accept: load HEAD, go BODY if pkt_len!=0 else stay IDLE.
//   HEAD flit_data: [address_length-1:0] = {y_rel,x_rel}, x_rel = pkt_dest_x - local_x,
//   y_rel = pkt_dest_y - local_y, two's complement truncated to field width;
//   [address_length+LEN_WIDTH-1:address_length] = pkt_len; remaining bits 0.
//   flit_type = 11 (HEAD_TAIL) if pkt_len==0 else 01. remaining <= pkt_len.
//  FSM BODY: data_ready = can_load. Each accepted word loads flit_data=data_in,
//   remaining decrements; type 10 (TAIL) when remaining==1 (go IDLE) else 00.
//  Latency: request/word accepted in cycle N -> flit_valid in N+1. Back-to-back flits at
//   one per cycle when flit_ready held high; next packet may be accepted in the cycle the
//   previous TAIL is loaded's following cycle (IDLE with can_load).
//  pkt_ready and data_ready never both 1. Inputs ignored when their ready is 0.
//  pkt_count increments by 1 in the cycle flit_valid & flit_ready & flit_type[1]; wraps FFFF->0.
//  busy = (state!=IDLE) | flit_valid.
// TESTING
//  local=(2,3), dest=(5,1), len=2, flit_ready=1 -> HEAD data[15:0]=16'hFE03 len=2, BODY, TAIL; pkt_count=1
//  local=(2,3), dest=(0,0), len=0 -> single HEAD_TAIL, data[15:0]=16'hFDFE; dest=(2,3) -> 16'h0000
//  flit_ready=0 for 5 cycles after HEAD -> flit held stable, data_ready=0, no words consumed
//  data_valid gaps mid-packet (len=3) -> no spurious flits; type sequence 01,00,00,10
//  rst pulse after 1 of 3 BODY flits -> flit_valid=0, pkt_count=0, next request sends clean HEAD
//  65536 len=0 packets -> pkt_count wraps to 0; continuous flit_ready=1 gives one flit/cycle

Source files
------------

// File: rtl/packet_injector.sv
// Local-port packet injector: turns a packet request into a HEAD flit that carries
// the relative address, then streams the payload words as BODY/TAIL flits through
// a single-entry registered output stage.
module packet_injector #(
  parameter int address_length   = 16,
  parameter int x_address_length = 8,
  parameter int y_address_length = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int LEN_WIDTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [x_address_length-1:0] local_x,
  input  logic [y_address_length-1:0] local_y,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  logic [x_address_length-1:0] pkt_dest_x,
  input  logic [y_address_length-1:0] pkt_dest_y,
  input  logic [LEN_WIDTH-1:0]        pkt_len,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        flit_valid,
  input  logic                        flit_ready,
  output logic [1:0]                  flit_type,
  output logic [DATA_WIDTH-1:0]       flit_data,
  output logic                        busy,
  output logic [15:0]                 pkt_count
);

  localparam logic [1:0] TYPE_BODY      = 2'b00;
  localparam logic [1:0] TYPE_HEAD      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [LEN_WIDTH-1:0]        remaining;
  logic                        can_load;
  logic                        pkt_accept;
  logic                        word_accept;
  logic [x_address_length-1:0] x_rel;
  logic [y_address_length-1:0] y_rel;
  logic [DATA_WIDTH-1:0]       head_data;

  // State register; a reset mid-packet simply abandons the packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake readies and next state; only one side is ever ready, selected by state.
  always_comb begin
    can_load   = !flit_valid || flit_ready;
    pkt_ready  = 1'b0;
    data_ready = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE: begin
        pkt_ready = can_load && !rst;
        if (pkt_valid && pkt_ready && (pkt_len != '0)) state_nxt = BODY;
      end
      BODY: begin
        data_ready = can_load && !rst;
        if (data_valid && data_ready && (remaining == LEN_WIDTH'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pkt_accept  = pkt_valid && pkt_ready;
  assign word_accept = data_valid && data_ready;
  assign busy        = (state != IDLE) || flit_valid;

  // HEAD word: wrapped two's-complement offsets in the low bits, length just above.
  always_comb begin
    x_rel     = pkt_dest_x - local_x;
    y_rel     = pkt_dest_y - local_y;
    head_data = '0;
    head_data[address_length-1:0] = {y_rel, x_rel};
    head_data[address_length+LEN_WIDTH-1:address_length] = pkt_len;
  end

  // Output flit register; contents only change when the slot is free or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_valid <= 1'b0;
      flit_type  <= TYPE_BODY;
      flit_data  <= '0;
    end else if (pkt_accept) begin
      flit_valid <= 1'b1;
      flit_type  <= (pkt_len == '0) ? TYPE_HEAD_TAIL : TYPE_HEAD;
      flit_data  <= head_data;
    end else if (word_accept) begin
      flit_valid <= 1'b1;
      flit_type  <= (remaining == LEN_WIDTH'(1)) ? TYPE_TAIL : TYPE_BODY;
      flit_data  <= data_in;
    end else if (flit_ready) begin
      flit_valid <= 1'b0;
    end
  end

  // Payload words still owed for the current packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              remaining <= '0;
    else if (pkt_accept)  remaining <= pkt_len;
    else if (word_accept) remaining <= remaining - LEN_WIDTH'(1);
  end

  // Completed packets: counted when the last flit leaves, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pkt_count <= '0;
    else if (flit_valid && flit_ready && flit_type[1]) pkt_count <= pkt_count + 16'd1;
  end

endmodule
